encoder83_seq: RTL and testbench

- Registered 8-to-3 priority encoder with request capture. It is the return path for the 3-to-8 select decoders.
- It takes 8 request lines in the decoder's output convention: active-low by default, inverted by `i_opt`.
- It latches request edges into a pending bitmap and presents the lowest pending index as a 3-bit code with a valid/ready handshake.
- Sits between decoded select/request lines and a controller that consumes one index per transfer.

---
 rtl/encoder83_seq.sv | 126 ++++++++++++
 tb/tb_encoder83_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder83_seq.sv
// ============================================================================
// encoder83_seq : registered 8-to-3 priority encoder with edge capture,
//                 pending bitmap and valid/ready grant handshake.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module encoder83_seq (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_y,
  input  logic       i_opt,
  input  logic       i_clr,
  input  logic       i_ready,
  output logic [2:0] o_sel,
  output logic       o_valid,
  output logic       o_multi,
  output logic [7:0] o_pend,
  output logic       o_ovf
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] req_q, req_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       multi_q, multi_d;
  logic       ovf_q, ovf_d;

  logic [7:0] w_req;
  logic [7:0] w_rise;
  logic [7:0] w_clr_mask;
  logic       w_hs;
  logic [2:0] w_lowest;
  logic [3:0] w_count;

  always_comb begin
    w_req      = i_opt ? i_y : ~i_y;
    w_rise     = w_req & ~req_q;
    w_hs       = valid_q & i_ready;
    w_clr_mask = w_hs ? (8'b1 << sel_q) : 8'h00;

    // Descending scan so the lowest set bit is the last one written.
    w_lowest = 3'd0;
    w_count  = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) begin
        w_lowest = 3'(i);
      end
      w_count = w_count + {3'b000, pend_q[i]};
    end

    req_d   = w_req;
    pend_d  = (pend_q & ~w_clr_mask) | w_rise;
    ovf_d   = ovf_q | (|(w_rise & pend_q & ~w_clr_mask));
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    multi_d = multi_q;

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          sel_d   = w_lowest;
          multi_d = (w_count > 4'd1);
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Clear wins over capture and handshake; req_d still tracks the lines.
    if (i_clr) begin
      pend_d  = 8'h00;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
      multi_d = 1'b0;
      sel_d   = 3'd0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      req_q   <= 8'h00;
      pend_q  <= 8'h00;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_sel   = sel_q;
  assign o_valid = valid_q;
  assign o_multi = multi_q;
  assign o_pend  = pend_q;
  assign o_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_encoder83_seq.sv
// Bench for encoder83_seq: directed scenarios plus random traffic against a
// transaction-level model, with grants checked by a scoreboard monitor.
`default_nettype none

module tb_encoder83_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] y;
  logic       opt;
  logic       clr;
  logic       ready;
  logic [2:0] o_sel;
  logic       o_valid;
  logic       o_multi;
  logic [7:0] o_pend;
  logic       o_ovf;

  encoder83_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_y     (y),
    .i_opt   (opt),
    .i_clr   (clr),
    .i_ready (ready),
    .o_sel   (o_sel),
    .o_valid (o_valid),
    .o_multi (o_multi),
    .o_pend  (o_pend),
    .o_ovf   (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the registered outputs should hold.
  logic [7:0] m_prev;
  logic [7:0] m_pend;
  logic       m_ovf;
  logic       m_valid;
  logic [2:0] m_sel;
  logic       m_multi;

  logic [3:0] exp_q[$];
  logic [3:0] g_log[$];
  logic [3:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = 8'h00;
    m_pend  = 8'h00;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_sel   = 3'd0;
    m_multi = 1'b0;
    exp_q.delete();
  endtask

  // One clock edge of the specified behaviour, using the current inputs.
  task automatic model_step();
    logic [7:0] r;
    logic [7:0] np;
    int freed;
    int lo;
    int cnt;
    r = opt ? y : ~y;
    if (clr) begin
      model_reset();
      m_prev = r;
      return;
    end
    freed = (m_valid && ready) ? int'(m_sel) : -1;
    np = m_pend;
    for (int i = 0; i < 8; i++) begin
      if (i == freed) np[i] = 1'b0;
      if (r[i] && !m_prev[i]) begin
        if (m_pend[i] && i != freed) m_ovf = 1'b1;
        np[i] = 1'b1;
      end
    end
    if (!m_valid) begin
      lo  = -1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        if (m_pend[i]) begin
          cnt++;
          if (lo < 0) lo = i;
        end
      end
      if (lo >= 0) begin
        m_sel   = 3'(lo);
        m_multi = (cnt > 1);
        m_valid = 1'b1;
        exp_q.push_back({m_multi, m_sel});
      end
    end else if (ready) begin
      m_valid = 1'b0;
    end
    m_pend = np;
    m_prev = r;
  endtask

  task automatic compare_all();
    check("pend",  o_pend,  m_pend);
    check("ovf",   o_ovf,   m_ovf);
    check("valid", o_valid, m_valid);
    check("sel",   o_sel,   m_sel);
    check("multi", o_multi, m_multi);
  endtask

  task automatic cycle(input logic [7:0] ty, input logic topt, input logic tclr, input logic tready);
    @(negedge clk);
    y     = ty;
    opt   = topt;
    clr   = tclr;
    ready = tready;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Scoreboard monitor: every completed handshake must match the oldest grant.
  always @(posedge clk) begin
    if (rst_n && !clr && o_valid && ready) begin
      if (exp_q.size() == 0) begin
        check("grant_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("grant_sel",   o_sel,   mon_e[2:0]);
        check("grant_multi", o_multi, mon_e[3]);
      end
      g_log.push_back({o_multi, o_sel});
    end
  end

  initial begin
    rst_n = 1'b0;
    y     = 8'hFF;
    opt   = 1'b0;
    clr   = 1'b0;
    ready = 1'b0;
    model_reset();

    // Reset state and idle lines
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {o_sel, o_valid, o_multi, o_pend, o_ovf}, 32'd0);
    release_reset();
    repeat (10) cycle(8'hFF, 1'b0, 1'b0, 1'b0);
    check("idle_valid", o_valid, 1'b0);
    check("idle_pend",  o_pend,  8'h00);
    check("idle_ovf",   o_ovf,   1'b0);

    // Single active-low request on bit 3
    g_log.delete();
    cycle(8'hF7, 1'b0, 1'b0, 1'b1);
    check("t2_pend", o_pend, 8'h08);
    cycle(8'hFF, 1'b0, 1'b0, 1'b1);
    check("t2_valid", o_valid, 1'b1);
    check("t2_sel",   o_sel,   3'd3);
    check("t2_multi", o_multi, 1'b0);
    cycle(8'hFF, 1'b0, 1'b0, 1'b1);
    check("t2_pend_after", o_pend,  8'h00);
    check("t2_valid_after", o_valid, 1'b0);
    check("t2_grants", g_log.size(), 32'd1);

    // Active-high, three requests at once, held then drained
    cycle(8'h00, 1'b1, 1'b1, 1'b0);
    cycle(8'hA4, 1'b1, 1'b0, 1'b0);
    repeat (5) cycle(8'h00, 1'b1, 1'b0, 1'b0);
    check("t3_sel_held", o_sel,   3'd2);
    check("t3_multi",    o_multi, 1'b1);
    check("t3_pend",     o_pend,  8'hA4);
    g_log.delete();
    repeat (8) cycle(8'h00, 1'b1, 1'b0, 1'b1);
    check("t3_grant_count", g_log.size(), 32'd3);
    if (g_log.size() == 3) begin
      check("t3_grant0", g_log[0], {1'b1, 3'd2});
      check("t3_grant1", g_log[1], {1'b1, 3'd5});
      check("t3_grant2", g_log[2], {1'b0, 3'd7});
    end
    check("t3_pend_final", o_pend, 8'h00);

    // Repeat request before service merges and flags overflow
    g_log.delete();
    cycle(8'h40, 1'b1, 1'b0, 1'b0);
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    cycle(8'h40, 1'b1, 1'b0, 1'b0);
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    check("t4_ovf",  o_ovf,  1'b1);
    check("t4_pend", o_pend, 8'h40);
    repeat (4) cycle(8'h00, 1'b1, 1'b0, 1'b1);
    check("t4_grant_count", g_log.size(), 32'd1);
    if (g_log.size() == 1) check("t4_grant_sel", g_log[0][2:0], 3'd6);
    cycle(8'h00, 1'b1, 1'b1, 1'b0);
    check("t4_ovf_cleared", o_ovf, 1'b0);

    // Rise on the bit being granted at the handshake edge
    g_log.delete();
    cycle(8'h10, 1'b1, 1'b0, 1'b0);
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    cycle(8'h10, 1'b1, 1'b0, 1'b1);
    check("t5_pend_kept", o_pend, 8'h10);
    check("t5_ovf",       o_ovf,  1'b0);
    repeat (4) cycle(8'h00, 1'b1, 1'b0, 1'b1);
    check("t5_grant_count", g_log.size(), 32'd2);
    if (g_log.size() == 2) begin
      check("t5_grant0", g_log[0][2:0], 3'd4);
      check("t5_grant1", g_log[1][2:0], 3'd4);
    end
    check("t5_ovf_end", o_ovf, 1'b0);

    // Asynchronous reset while presenting
    cycle(8'h30, 1'b1, 1'b0, 1'b0);
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    check("t6_presenting", {o_valid, o_sel, o_pend}, {1'b1, 3'd4, 8'h30});
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", {o_sel, o_valid, o_multi, o_pend, o_ovf}, 32'd0);
    model_reset();
    release_reset();

    // Synchronous clear while presenting, with a rise in the same cycle
    cycle(8'h30, 1'b1, 1'b0, 1'b0);
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    check("t6b_presenting", o_valid, 1'b1);
    cycle(8'h01, 1'b1, 1'b1, 1'b0);
    check("t6b_clear", {o_sel, o_valid, o_multi, o_pend, o_ovf}, 32'd0);
    cycle(8'h01, 1'b1, 1'b0, 1'b0);
    check("t6b_no_late_rise", o_pend, 8'h00);
    cycle(8'h00, 1'b1, 1'b0, 1'b0);

    // Random traffic; polarity only moves under clear
    for (int n = 0; n < 600; n++) begin
      logic       rc;
      logic       ro;
      logic [7:0] ry;
      rc = ($urandom_range(0, 39) == 0);
      ro = opt;
      if (rc && $urandom_range(0, 1) == 1) ro = ~opt;
      ry = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : y;
      cycle(ry, ro, rc, ($urandom_range(0, 3) != 0));
    end

    repeat (20) cycle(y, opt, 1'b0, 1'b1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
